// File: rtl/pri_enco_if.sv
// rtl/pri_enco_if.sv - request/index bundle for the registered priority encoder
interface pri_enco_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 3
);
    logic             en;
    logic [IN_W-1:0]  in;
    logic [OUT_W-1:0] y;
    logic             valid;

    modport master (output en, output in, input y, input valid);
    modport slave  (input en, input in, output y, output valid);
endinterface

// File: rtl/pri_enco.sv
// rtl/pri_enco.sv - 8-to-3 priority encoder, highest set bit wins, registered outputs
module pri_enco #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 3
) (
    input  logic     clk,
    input  logic     rst,
    pri_enco_if.slave bus
);
    logic [OUT_W-1:0] idx_next;
    logic             any_next;

    // Ascending scan: the last hit is the highest-numbered set bit.
    always_comb begin
        idx_next = '0;
        any_next = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (bus.in[i]) begin
                idx_next = OUT_W'(i);
                any_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.y     <= '0;
            bus.valid <= 1'b0;
        end else if (bus.en) begin
            bus.y     <= idx_next;
            bus.valid <= any_next;
        end
    end
endmodule

// File: tb/tb_pri_enco.sv
// tb/tb_pri_enco.sv - vector table, corner sequences and random model check for pri_enco
module tb_pri_enco;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    pri_enco_if #(.IN_W(8), .OUT_W(3)) bus ();

    pri_enco #(.IN_W(8), .OUT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        logic [7:0] in;
        logic [2:0] exp_y;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [2:0] exp_y, input logic exp_valid);
        n_cmp++;
        if (bus.y !== exp_y || bus.valid !== exp_valid) begin
            n_bad++;
            $display("FAIL %s: got y=%0d valid=%0b, want y=%0d valid=%0b",
                     name, bus.y, bus.valid, exp_y, exp_valid);
        end
    endtask

    // Drive on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic r, input logic e, input logic [7:0] v);
        @(negedge clk);
        rst    = r;
        bus.en = e;
        bus.in = v;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input string n, input logic r, input logic e,
                                input logic [7:0] v, input logic [2:0] ey, input logic ev);
        vec_t t;
        t.name = n; t.rst = r; t.en = e; t.in = v; t.exp_y = ey; t.exp_valid = ev;
        vecs.push_back(t);
    endfunction

    logic [2:0] m_y;
    logic       m_valid;
    logic       r_r, r_e;
    logic [7:0] r_in;

    initial begin
        rst    = 1'b1;
        bus.en = 1'b0;
        bus.in = 8'h00;

        add("reset0", 1, 1, 8'hFF, 3'd0, 0);
        add("reset1", 1, 1, 8'hFF, 3'd0, 0);
        add("zero",   0, 1, 8'h00, 3'd0, 0);
        for (int i = 7; i >= 0; i--)
            add($sformatf("onehot%0d", i), 0, 1, 8'(1 << i), 3'(i), 1);
        add("prio_5b", 0, 1, 8'b01011011, 3'd6, 1);
        add("prio_03", 0, 1, 8'b00000011, 3'd1, 1);
        add("prio_ff", 0, 1, 8'hFF,       3'd7, 1);
        add("zero_after", 0, 1, 8'h00,    3'd0, 0);

        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].en, vecs[k].in);
            check(vecs[k].name, vecs[k].exp_y, vecs[k].exp_valid);
        end

        // Hold: en=0 must freeze outputs regardless of in.
        step(0, 1, 8'b00100000);
        check("hold_load", 3'd5, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 8'b10000000);
            check($sformatf("hold%0d", i), 3'd5, 1);
        end

        // Mid-run reset overrides en.
        step(0, 1, 8'h80);
        check("pre_rst", 3'd7, 1);
        step(1, 1, 8'h80);
        check("mid_rst", 3'd0, 0);
        step(0, 1, 8'h80);
        check("post_rst", 3'd7, 1);

        // Random against a model: index = floor(log2(in)), held on en=0.
        m_y     = 3'd7;
        m_valid = 1'b1;
        for (int n = 0; n < 400; n++) begin
            r_r  = ($urandom_range(0, 15) == 0);
            r_e  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       r_in = 8'h00;
                1:       r_in = 8'(1 << $urandom_range(0, 7));
                default: r_in = 8'($urandom);
            endcase
            if (r_r) begin
                m_y = 3'd0; m_valid = 1'b0;
            end else if (r_e) begin
                m_valid = (r_in != 0);
                m_y     = (r_in == 0) ? 3'd0 : 3'($clog2(int'(r_in) + 1) - 1);
            end
            step(r_r, r_e, r_in);
            check($sformatf("rand%0d_in%02h", n, r_in), m_y, m_valid);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
